// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter/sequencer that shares one block-wide main-memory port
//   between the L2 refill path (port 0) and the L2 writeback path (port 1).
//   It runs one block transaction at a time. Each transaction issues a
//   one-cycle read or write strobe and then waits for mem_ready. It returns
//   read data, or an error if TIMEOUT expires first.
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   req/we[1:0]           per-port request and direction (1 = write block)
//   addr0/addr1           per-port word address
//   wdata0/wdata1         per-port write block
//   done[1:0], err        one-cycle completion pulse to the granted port, timeout flag
//   rdata                 read block, valid in the done cycle
//   busy                  transaction in flight
//   mem_*                 block-aligned memory port: strobes, address, data, ready
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [1:0]                       req,
  input  logic [1:0]                       we,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] wdata0,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] wdata1,
  output logic [1:0]                       done,
  output logic                             err,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] rdata,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
  output logic                             mem_read,
  output logic                             mem_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
  input  logic                             mem_ready
);

  localparam int BW = BLOCK_SIZE * DATA_WIDTH;
  // With TIMEOUT == 0 the timer is unused; keep it one bit wide so it stays legal.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]         TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_gnt_q, last_gnt_d;
  logic                    gnt_q, gnt_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BW-1:0]           wdata_q, wdata_d;
  logic [BW-1:0]           rdata_q, rdata_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    win;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    timer_d    = timer_q;
    // A lone request wins outright; on a tie the port not granted last time wins.
    win        = (req == 2'b11) ? ~last_gnt_q : req[1];

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d      = win;
          last_gnt_d = win;
          we_d       = win ? we[1] : we[0];
          addr_d     = (win ? addr1 : addr0) & ALIGN_MASK;
          wdata_d    = win ? wdata1 : wdata0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          if (!we_q) rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      timer_q    <= timer_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_read  = (state_q == S_ISSUE) && !we_q;
  assign mem_write = (state_q == S_ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign done      = (state_q == S_DONE) ? {gnt_q, ~gnt_q} : 2'b00;
  assign err       = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int BS = 16;
  localparam int TO = 4;
  localparam int BW = DW * BS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, we;
  logic [AW-1:0] addr0, addr1;
  logic [BW-1:0] wdata0, wdata1;
  logic [1:0]    done;
  logic          err, busy, mem_read, mem_write, mem_ready;
  logic [BW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: whose turn it is on a tie, and the last block read.
  bit            m_last;
  logic [BW-1:0] m_rdata;

  mem_port_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BLOCK_SIZE(BS),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [BW-1:0] d);
    if (p == 0) begin we[0] = w; addr0 = a; wdata0 = d; end
    else        begin we[1] = w; addr1 = a; wdata1 = d; end
  endtask

  // One complete transaction, starting in an idle cycle. The memory raises
  // ready in WAIT cycle `delay` (counted from 0); delays >= TO time out.
  task automatic run_txn(input logic [1:0] r, input int delay, input bit drop_req,
                         input bit spurious);
    bit            w, got;
    logic          wexp;
    logic [AW-1:0] a;
    logic [BW-1:0] wd, rd;
    int            k;
    w      = (r == 2'b11) ? ~m_last : r[1];
    m_last = w;
    wexp   = we[w];
    a      = (w ? addr1 : addr0) & 16'hFFF0;
    wd     = w ? wdata1 : wdata0;
    rd     = '0;
    req       = r;
    mem_ready = spurious;
    mem_rdata = rand_block();
    tick();
    // strobe cycle
    chk("issue_busy", busy, 1'b1);
    chk("issue_done", done, 2'b00);
    chk("issue_rd", mem_read, !wexp);
    chk("issue_wr", mem_write, wexp);
    chk("issue_addr", mem_addr, a);
    if (wexp) chk("issue_wdata", mem_wdata, wd);
    tick();
    mem_ready = 1'b0;
    if (drop_req) req = 2'b00;
    k   = 0;
    got = 0;
    forever begin
      chk("wait_rd", mem_read, 1'b0);
      chk("wait_wr", mem_write, 1'b0);
      chk("wait_done", done, 2'b00);
      chk("wait_addr", mem_addr, a);
      if (k == delay) begin
        rd        = rand_block();
        mem_rdata = rd;
        mem_ready = 1'b1;
        got       = 1;
      end
      tick();
      mem_ready = 1'b0;
      if (got || k == TO - 1) break;
      k++;
    end
    if (got && !wexp) m_rdata = rd;
    chk("done_pulse", done, w ? 2'b10 : 2'b01);
    chk("done_err", err, !got);
    chk("done_rdata", rdata, m_rdata);
    tick();
    chk("idle_done", done, 2'b00);
    chk("idle_busy", busy, 1'b0);
    chk("idle_err", err, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; mem_rdata = '0; mem_ready = 1'b0;
    m_last = 1'b1; m_rdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 2'b00);
    chk("rst_addr", mem_addr, '0);
    chk("rst_rdata", rdata, '0);
    rst_n = 1'b1;
    tick();

    // Port 0 read, unaligned address, 1-cycle memory.
    set_port(0, 1'b0, 16'h0013, '0);
    run_txn(2'b01, 0, 1'b0, 1'b0);
    req = 2'b00;
    tick();

    // Port 1 write with a pattern.
    set_port(1, 1'b1, 16'h0040, {BW/32{32'hA5C3_0F96}});
    run_txn(2'b10, 1, 1'b0, 1'b0);

    // Both held continuously: grants alternate, one idle cycle between.
    set_port(0, 1'b0, 16'h0100, rand_block());
    set_port(1, 1'b1, 16'h0200, rand_block());
    for (int i = 0; i < 4; i++) run_txn(2'b11, 0, 1'b0, 1'b0);

    // Timeout: ready never comes.
    run_txn(2'b01, 99, 1'b0, 1'b0);

    // Spurious ready in IDLE/ISSUE and req dropped in WAIT.
    run_txn(2'b10, 2, 1'b1, 1'b1);

    // Reset while in WAIT.
    req = 2'b11;
    tick(); tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_rd", mem_read, 1'b0);
    chk("arst_wr", mem_write, 1'b0);
    chk("arst_addr", mem_addr, '0);
    chk("arst_wdata", mem_wdata, '0);
    chk("arst_rdata", rdata, '0);
    chk("arst_done", done, 2'b00);
    chk("arst_err", err, 1'b0);
    m_last = 1'b1; m_rdata = '0;
    tick();
    rst_n = 1'b1;
    run_txn(2'b11, 0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      set_port(0, 1'($urandom), 16'($urandom), rand_block());
      set_port(1, 1'($urandom), 16'($urandom), rand_block());
      run_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 5)),
              1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
